imm_stage: RTL and testbench
============================

# imm_stage

Registered, parametrised immediate-generation stage between fetch and the decode/execute boundary. Each cycle it accepts one 32-bit RV instruction with its PC and classifies the immediate format. It produces the sign- or zero-extended immediate at XLEN width and the precomputed PC-relative sum. Results leave through a valid/ready interface with a 2-entry skid buffer, so fetch never loses an instruction under back-pressure.

## Interface
- XLEN, default 32: datapath width, legal values 32 or 64; immediates and targets are extended to XLEN.
- EN_W_OPS, default 0: when 1 and XLEN=64, opcode 0011011 (ALU_I_W) is legal with I-format.
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discards all buffered entries and the input beat this cycle.
- valid_i  in  1  instruction beat present.
- ready_o  out  1  stage can accept a beat; registered.
- instr_i  in  32  raw instruction word.
- pc_i  in  XLEN  PC of instr_i.
- valid_o  out  1  output beat present.
- ready_i  in  1  consumer accepts the output beat.
- imm_o  out  XLEN  extended immediate.
- fmt_o  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
- target_o  out  XLEN  pc + imm_o, modulo 2^XLEN.
- illegal_o  out  1  opcode not recognised.

## Operation
- Opcode decode uses instr[6:0]:
  - I-format: 0010011, 0000011, 1100111.
  - S-format: 0100011.
  - B-format: 1100011.
  - U-format: 0110111, 0010111.
  - J-format: 1101111.
  - 1110011 (SYSTEM): Z-format when funct3[2]=1; otherwise NONE and legal.
  - 0011011: I-format when XLEN=64 and EN_W_OPS=1; otherwise illegal.
- Any other opcode, including instr[1:0]≠11: fmt NONE, imm 0, illegal_o=1.
- Immediate construction:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: sext({instr[31:12], 12'b0}). Sign extension applies above bit 31 when XLEN=64.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Z: zero-extended instr[19:15].
  - NONE: 0.
- target_o = pc + imm, computed for every format and truncated to XLEN; no overflow flag.
- Buffering has two slots: OUT (drives the outputs) and SKID.
  - States: EMPTY (OUT and SKID empty), ONE (OUT full), TWO (OUT and SKID full).
  - Accept occurs when valid_i & ready_o & !flush_i. Drain occurs when valid_o & ready_i.
  - EMPTY, accept → ONE.
  - ONE: accept with drain → ONE, new beat in OUT. Accept without drain → TWO, beat in SKID. Drain without accept → EMPTY.
  - TWO: ready_o=0. Drain → ONE, SKID moves to OUT.
- Ordering is strictly FIFO; no beat is duplicated or dropped.
- Combinational immediate/target logic is placed on the input side; both slots store computed results.
- flush_i takes priority over accept and drain: next state EMPTY, valid_o=0, ready_o=1. The beat presented on a flush cycle is dropped.
- Output fields are held stable while valid_o=1 and ready_i=0.

## Timing
- Reset values:
  - valid_o=0, ready_o=1.
  - imm_o, target_o, fmt_o and illegal_o are 0.
  - State EMPTY.
- Latency: a beat accepted in cycle N appears on the outputs in cycle N+1.
- Throughput: 1 beat per cycle while ready_i=1.
- ready_o is a flop output (no combinational path from ready_i). It is 0 only in TWO.
- Asserting rstn_i low mid-operation clears both slots immediately, without waiting for a clock edge.
- Output fields are don't-care when valid_o=0, but they must hold their last value rather than toggle.

## Test plan
- XLEN=32, pc=0x100:
  - 0xFFF00093 (addi -1) → imm 0xFFFFFFFF, fmt I, target 0xFF.
  - 0xFE002C23 (sw, -8) → imm 0xFFFFFFF8, fmt S.
- XLEN=32, pc=0x100:
  - 0xFE000EE3 (beq -4) → imm 0xFFFFFFFC, fmt B, target 0xFC.
  - 0x0010006F (jal +2048) → imm 0x800, fmt J, target 0x900.
- XLEN=64:
  - 0x80000037 (lui) → imm 0xFFFFFFFF80000000, fmt U.
  - 0x0000001B with EN_W_OPS=0 → illegal_o=1, imm 0.
  - 0x0000001B with EN_W_OPS=1 → fmt I.
- 0x300FD073 (csrrwi, zimm 31) → imm 0x1F, fmt Z. 0x00000000 → illegal_o=1, fmt NONE.
- Back-pressure:
  - Drive beats A, B, C, D with valid_i=1 and ready_i=0.
  - Required: A, B accepted; ready_o=0 from the cycle after B is accepted.
  - Raise ready_i: outputs A, B, C, D in order, one per cycle, no gaps after the first drain.
- Flush and reset:
  - In state TWO, pulse flush_i → next cycle valid_o=0, ready_o=1; the flushed beats never appear.
  - Repeat with rstn_i low mid-cycle → outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/imm_stage_if.sv
// Handshake bundle for imm_stage: fetch-side beat in, decoded immediate beat out.
// The slave modport is the stage itself; the master modport is its environment.
interface imm_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] imm_o;
  logic [2:0]      fmt_o;
  logic [XLEN-1:0] target_o;
  logic            illegal_o;

  modport slave (
    input  valid_i, instr_i, pc_i, ready_i,
    output ready_o, valid_o, imm_o, fmt_o, target_o, illegal_o
  );

  modport master (
    output valid_i, instr_i, pc_i, ready_i,
    input  ready_o, valid_o, imm_o, fmt_o, target_o, illegal_o
  );
endinterface

// File: rtl/imm_stage.sv
// Immediate-generation stage: decodes the RV immediate and PC-relative target on the
// input side, then buffers results in a 2-slot (OUT + SKID) valid/ready pipeline.
module imm_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned EN_W_OPS = 0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        flush_i,
  imm_stage_if.slave  bus
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    fmt_t            fmt;
    logic            illegal;
  } beat_t;

  localparam bit W_OPS_LEGAL = (XLEN == 64) && (EN_W_OPS == 1);

  logic [31:0]     w_instr;
  logic [6:0]      w_opcode;
  fmt_t            w_fmt;
  logic            w_illegal;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  beat_t           w_beat;

  state_t r_state, w_state_nxt;
  beat_t  r_out, w_out_nxt;
  beat_t  r_skid, w_skid_nxt;
  logic   r_valid;
  logic   r_ready;
  logic   w_acc;
  logic   w_drn;

  assign w_instr  = bus.instr_i;
  assign w_opcode = w_instr[6:0];

  always_comb begin
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    case (w_opcode)
      7'b0010011, 7'b0000011, 7'b1100111: w_fmt = FMT_I;
      7'b0100011:                         w_fmt = FMT_S;
      7'b1100011:                         w_fmt = FMT_B;
      7'b0110111, 7'b0010111:             w_fmt = FMT_U;
      7'b1101111:                         w_fmt = FMT_J;
      7'b1110011:                         w_fmt = w_instr[14] ? FMT_Z : FMT_NONE;
      7'b0011011: begin
        if (W_OPS_LEGAL) w_fmt = FMT_I;
        else             w_illegal = 1'b1;
      end
      default:                            w_illegal = 1'b1;
    endcase
  end

  // Every format is built as a 32-bit signed value first; only Z is zero-based,
  // so one sign-extending cast covers both XLEN widths.
  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
      FMT_S: w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      FMT_B: w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                        w_instr[30:25], w_instr[11:8], 1'b0};
      FMT_U: w_imm32 = {w_instr[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                        w_instr[20], w_instr[30:21], 1'b0};
      FMT_Z: w_imm32 = {27'b0, w_instr[19:15]};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  always_comb begin
    w_beat         = '0;
    w_beat.imm     = w_imm;
    w_beat.target  = bus.pc_i + w_imm;
    w_beat.fmt     = w_fmt;
    w_beat.illegal = w_illegal;
  end

  assign w_acc = bus.valid_i & r_ready & ~flush_i;
  assign w_drn = r_valid & bus.ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_skid_nxt  = r_skid;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_out_nxt   = w_beat;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && w_drn) begin
            w_out_nxt = w_beat;
          end else if (w_acc) begin
            w_skid_nxt  = w_beat;
            w_state_nxt = ST_TWO;
          end else if (w_drn) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drn) begin
            w_out_nxt   = r_skid;
            w_state_nxt = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // valid/ready are decoded from the next state so both leave directly from flops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt != ST_EMPTY);
      r_ready <= (w_state_nxt != ST_TWO);
      r_out   <= w_out_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  assign bus.valid_o   = r_valid;
  assign bus.ready_o   = r_ready;
  assign bus.imm_o     = r_out.imm;
  assign bus.target_o  = r_out.target;
  assign bus.fmt_o     = r_out.fmt;
  assign bus.illegal_o = r_out.illegal;

endmodule

// File: tb/tb_imm_stage.sv
// Bench for imm_stage: three configurations (32, 64, 64+W ops) share one stimulus
// stream; a queue-based FIFO model and arithmetic immediate decoder supply expectations.
module tb_imm_stage;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc    = '0;

  imm_stage_if #(.XLEN(32)) if32 ();
  imm_stage_if #(.XLEN(64)) if64n ();
  imm_stage_if #(.XLEN(64)) if64w ();

  assign if32.valid_i  = valid;
  assign if32.ready_i  = ready;
  assign if32.instr_i  = instr;
  assign if32.pc_i     = pc[31:0];
  assign if64n.valid_i = valid;
  assign if64n.ready_i = ready;
  assign if64n.instr_i = instr;
  assign if64n.pc_i    = pc;
  assign if64w.valid_i = valid;
  assign if64w.ready_i = ready;
  assign if64w.instr_i = instr;
  assign if64w.pc_i    = pc;

  imm_stage #(.XLEN(32), .EN_W_OPS(0)) u_dut32 (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .bus(if32));
  imm_stage #(.XLEN(64), .EN_W_OPS(0)) u_dut64n (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .bus(if64n));
  imm_stage #(.XLEN(64), .EN_W_OPS(1)) u_dut64w (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .bus(if64w));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } mbeat_t;

  mbeat_t      q[$];
  int          errors = 0;
  int          checks = 0;
  bit          last_acc;
  logic [63:0] e_imm[3];
  logic [63:0] e_tgt[3];
  logic [2:0]  e_fmt[3];
  logic        e_ill[3];
  logic [6:0]  ops[10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h1B};

  function automatic void ref_dec(input logic [31:0] ins, input logic [63:0] pcv,
                                  input bit x64, input bit enw,
                                  output logic [63:0] imm, output logic [63:0] tgt,
                                  output logic [2:0] fmt, output logic ill);
    longint v;
    v   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: fmt = 3'd1;
      7'h23:               fmt = 3'd2;
      7'h63:               fmt = 3'd3;
      7'h37, 7'h17:        fmt = 3'd4;
      7'h6F:               fmt = 3'd5;
      7'h73:               fmt = ins[14] ? 3'd6 : 3'd0;
      7'h1B:               if (x64 && enw) fmt = 3'd1; else ill = 1'b1;
      default:             ill = 1'b1;
    endcase
    case (fmt)
      3'd1: begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; end
      3'd2: begin v = longint'({ins[31:25], ins[11:7]}); if (v >= 2048) v -= 4096; end
      3'd3: begin
        v = longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd4: begin
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v -= 64'sd4294967296;
      end
      3'd5: begin
        v = longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      3'd6: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    imm = v;
    tgt = pcv + imm;
    if (!x64) begin
      imm[63:32] = '0;
      tgt[63:32] = '0;
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned sel;
    w   = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 10) w[6:0] = ops[sel];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    for (int d = 0; d < 3; d++) begin
      e_imm[d] = '0; e_tgt[d] = '0; e_fmt[d] = '0; e_ill[d] = 1'b0;
    end
  endtask

  task automatic chk_dut(input int d, input logic v, input logic r, input logic [63:0] im,
                         input logic [63:0] tg, input logic [2:0] f, input logic il);
    chk($sformatf("dut%0d.valid_o", d), 64'(v), 64'(q.size() > 0));
    chk($sformatf("dut%0d.ready_o", d), 64'(r), 64'(q.size() < 2));
    chk($sformatf("dut%0d.imm_o", d), im, e_imm[d]);
    chk($sformatf("dut%0d.target_o", d), tg, e_tgt[d]);
    chk($sformatf("dut%0d.fmt_o", d), 64'(f), 64'(e_fmt[d]));
    chk($sformatf("dut%0d.illegal_o", d), 64'(il), 64'(e_ill[d]));
  endtask

  // When nothing is valid the expected fields stay at the last shown beat.
  task automatic check_all();
    logic [63:0] im, tg;
    logic [2:0]  f;
    logic        il;
    if (q.size() > 0) begin
      for (int d = 0; d < 3; d++) begin
        ref_dec(q[0].instr, q[0].pc, d != 0, d == 2, im, tg, f, il);
        e_imm[d] = im; e_tgt[d] = tg; e_fmt[d] = f; e_ill[d] = il;
      end
    end
    chk_dut(0, if32.valid_o, if32.ready_o, 64'(if32.imm_o), 64'(if32.target_o),
            if32.fmt_o, if32.illegal_o);
    chk_dut(1, if64n.valid_o, if64n.ready_o, if64n.imm_o, if64n.target_o,
            if64n.fmt_o, if64n.illegal_o);
    chk_dut(2, if64w.valid_o, if64w.ready_o, if64w.imm_o, if64w.target_o,
            if64w.fmt_o, if64w.illegal_o);
  endtask

  task automatic cycle();
    bit acc, drn;
    acc = rstn && valid && (q.size() < 2) && !flush;
    drn = rstn && (q.size() > 0) && ready;
    @(posedge clk);
    if (!rstn) begin
      clear_model();
    end else if (flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{instr: instr, pc: pc});
    end
    last_acc = acc;
    #1;
    check_all();
  endtask

  task automatic send_beat(input logic [31:0] ins, input logic [63:0] p);
    valid = 1'b1;
    instr = ins;
    pc    = p;
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (last_acc) break;
    end
    chk("send_accepted", 64'(last_acc), 64'd1);
    valid = 1'b0;
  endtask

  task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
    ready = 1'b0;
    valid = 1'b1;
    instr = a;
    cycle();
    instr = b;
    cycle();
    valid = 1'b0;
    chk("fill_two_ready", 64'(if32.ready_o), 64'd0);
  endtask

  initial begin
    logic [31:0] bp[4];
    logic [63:0] got[4];
    int          idx;
    int          n;
    bit          r_sel;

    clear_model();
    rstn = 1'b0;
    repeat (2) cycle();
    chk("rst_valid", 64'(if32.valid_o), 64'd0);
    chk("rst_ready", 64'(if32.ready_o), 64'd1);
    chk("rst_imm", if64w.imm_o, 64'd0);
    rstn = 1'b1;
    cycle();

    send_beat(32'hFFF00093, 64'h100);
    chk("addi_imm", 64'(if32.imm_o), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(if32.fmt_o), 64'd1);
    chk("addi_target", 64'(if32.target_o), 64'hFF);
    send_beat(32'hFE002C23, 64'h100);
    chk("sw_imm", 64'(if32.imm_o), 64'hFFFF_FFF8);
    chk("sw_fmt", 64'(if32.fmt_o), 64'd2);
    send_beat(32'hFE000EE3, 64'h100);
    chk("beq_imm", 64'(if32.imm_o), 64'hFFFF_FFFC);
    chk("beq_fmt", 64'(if32.fmt_o), 64'd3);
    chk("beq_target", 64'(if32.target_o), 64'hFC);
    send_beat(32'h0010006F, 64'h100);
    chk("jal_imm", 64'(if32.imm_o), 64'h800);
    chk("jal_fmt", 64'(if32.fmt_o), 64'd5);
    chk("jal_target", 64'(if32.target_o), 64'h900);
    send_beat(32'h80000037, 64'h0);
    chk("lui64_imm", if64n.imm_o, 64'hFFFF_FFFF_8000_0000);
    chk("lui64_fmt", 64'(if64n.fmt_o), 64'd4);
    send_beat(32'h0000001B, 64'h0);
    chk("w_off_illegal", 64'(if64n.illegal_o), 64'd1);
    chk("w_off_imm", if64n.imm_o, 64'd0);
    chk("w_on_fmt", 64'(if64w.fmt_o), 64'd1);
    chk("w_on_illegal", 64'(if64w.illegal_o), 64'd0);
    send_beat(32'h300FD073, 64'h0);
    chk("csrrwi_imm", 64'(if32.imm_o), 64'h1F);
    chk("csrrwi_fmt", 64'(if32.fmt_o), 64'd6);
    send_beat(32'h00000000, 64'h0);
    chk("zero_illegal", 64'(if32.illegal_o), 64'd1);
    chk("zero_fmt", 64'(if32.fmt_o), 64'd0);
    cycle();
    chk("drained_valid", 64'(if32.valid_o), 64'd0);

    // Back-pressure: four beats, only two fit before ready_o drops.
    bp = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
    ready = 1'b0;
    valid = 1'b1;
    idx   = 0;
    instr = bp[0];
    repeat (4) begin
      cycle();
      if (last_acc) begin
        idx++;
        if (idx < 4) instr = bp[idx];
        else valid = 1'b0;
      end
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_ready_low", 64'(if32.ready_o), 64'd0);
    n = 0;
    got[0] = 64'(if32.imm_o);
    n = 1;
    ready = 1'b1;
    repeat (3) begin
      cycle();
      if (last_acc) begin
        idx++;
        if (idx < 4) instr = bp[idx];
        else valid = 1'b0;
      end
      if (if32.valid_o && n < 4) begin
        got[n] = 64'(if32.imm_o);
        n++;
      end
    end
    valid = 1'b0;
    chk("bp_count", 64'(n), 64'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("bp_order%0d", k), got[k], 64'(k + 1));
    cycle();
    chk("bp_empty", 64'(if32.valid_o), 64'd0);

    // Flush while both slots are full, with a beat on the input.
    fill_two(32'h00500093, 32'h00600093);
    flush = 1'b1;
    valid = 1'b1;
    instr = 32'h00700093;
    cycle();
    flush = 1'b0;
    valid = 1'b0;
    chk("flush_valid", 64'(if32.valid_o), 64'd0);
    chk("flush_ready", 64'(if32.ready_o), 64'd1);
    ready = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset mid-cycle while full.
    fill_two(32'h00800093, 32'h00900093);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 64'(if64w.valid_o), 64'd0);
    chk("arst_ready", 64'(if64w.ready_o), 64'd1);
    chk("arst_imm", if64w.imm_o, 64'd0);
    chk("arst_target", if64w.target_o, 64'd0);
    chk("arst_fmt", 64'(if32.fmt_o), 64'd0);
    chk("arst_illegal", 64'(if32.illegal_o), 64'd0);
    clear_model();
    cycle();
    rstn = 1'b1;
    cycle();

    for (int k = 0; k < 400; k++) begin
      r_sel = ($urandom_range(0, 3) != 0);
      valid = r_sel;
      ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      instr = rand_instr();
      pc    = {$urandom, $urandom};
      cycle();
    end
    flush = 1'b0;
    valid = 1'b0;
    ready = 1'b1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
